// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds the FSM state encoding, port indices, idle bus values and default parameters.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

  localparam logic [15:0] IDLE_ADDR          = 16'hFFFF;
  localparam int          DEF_TIMEOUT_CYCLES = 255;
  localparam logic [31:0] DEF_ERR_DATA       = 32'hDEADBEEF;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wr_mask;
  } port_req_t;

  function automatic arb_state_e own_state(input logic idx);
    return idx ? ST_OWN1 : ST_OWN0;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port that did not win last time is chosen.
// Purely combinational; no backpressure of its own.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = PORT_CPU;
    case (i_req)
      2'b01:   o_grant = PORT_CPU;
      2'b10:   o_grant = PORT_LDR;
      2'b11:   o_grant = ~i_last_grant;
      default: o_grant = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (port 0) and loader (port 1) onto one memory port with read timeout.
// Grant one cycle after request; requesters are held off until their completion pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_DATA       = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_ren,
  input  logic        m0_wen,
  input  logic [15:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wr_mask,
  output logic [31:0] m0_rdata,
  output logic        m0_rd_valid,
  output logic        m0_wr_done,
  input  logic        m1_ren,
  input  logic        m1_wen,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wr_mask,
  output logic [31:0] m1_rdata,
  output logic        m1_rd_valid,
  output logic        m1_wr_done,
  output logic        mem_ren,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wr_mask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rd_valid,
  output logic        err
);

  // Timeout fires on the wait cycle where the count already holds TIMEOUT_CYCLES-1.
  localparam logic [15:0] TMO_LAST_CNT = 16'(TIMEOUT_CYCLES - 1);

  arb_state_e  r_state;
  arb_state_e  w_state_nxt;
  logic        r_last_grant;
  logic [15:0] r_wait_cnt;
  logic        r_err;

  port_req_t   w_port0;
  port_req_t   w_port1;
  port_req_t   w_cur;
  logic        w_own_idx;
  logic [1:0]  w_req;
  logic        w_grant_idx;
  logic        w_grant_vld;
  logic        w_grant_now;
  logic        w_rd_done;
  logic        w_wr_done;
  logic        w_timeout;
  logic        w_rd_wait;
  logic [31:0] w_rdata;

  assign w_port0 = '{ren: m0_ren, wen: m0_wen, addr: m0_addr, wdata: m0_wdata, wr_mask: m0_wr_mask};
  assign w_port1 = '{ren: m1_ren, wen: m1_wen, addr: m1_addr, wdata: m1_wdata, wr_mask: m1_wr_mask};

  assign w_own_idx = (r_state == ST_OWN1) ? PORT_LDR : PORT_CPU;
  assign w_cur     = (w_own_idx == PORT_LDR) ? w_port1 : w_port0;
  assign w_req     = {m1_ren | m1_wen, m0_ren | m0_wen};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant_idx),
    .o_valid      (w_grant_vld)
  );

  assign w_grant_now = (r_state == ST_IDLE) && w_grant_vld;
  assign w_rd_wait   = mem_ren && !mem_rd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = IDLE_ADDR;
    mem_wdata   = '0;
    mem_wr_mask = 4'b1111;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    w_timeout   = 1'b0;
    w_rdata     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = own_state(w_grant_idx);
        end
      end
      ST_OWN0, ST_OWN1: begin
        mem_addr    = w_cur.addr;
        mem_wdata   = w_cur.wdata;
        mem_wr_mask = w_cur.wr_mask;
        w_state_nxt = ST_IDLE;
        // A write wins over a simultaneous read request.
        if (w_cur.wen) begin
          mem_wen   = 1'b1;
          w_wr_done = 1'b1;
        end else if (w_cur.ren) begin
          mem_ren = 1'b1;
          if (mem_rd_valid) begin
            w_rd_done = 1'b1;
            w_rdata   = mem_rdata;
          end else if (r_wait_cnt == TMO_LAST_CNT) begin
            w_rd_done = 1'b1;
            w_timeout = 1'b1;
            w_rdata   = ERR_DATA;
          end else begin
            w_state_nxt = r_state;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= PORT_LDR;
      r_wait_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_grant_now) begin
        r_last_grant <= w_grant_idx;
        r_wait_cnt   <= '0;
      end else if (w_rd_wait) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign m0_rd_valid = w_rd_done && (w_own_idx == PORT_CPU);
  assign m1_rd_valid = w_rd_done && (w_own_idx == PORT_LDR);
  assign m0_wr_done  = w_wr_done && (w_own_idx == PORT_CPU);
  assign m1_wr_done  = w_wr_done && (w_own_idx == PORT_LDR);
  assign m0_rdata    = m0_rd_valid ? w_rdata : '0;
  assign m1_rdata    = m1_rd_valid ? w_rdata : '0;
  assign err         = r_err | w_timeout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle table, reset/alternation sequences, random vs model.
module tb_mem_arbiter;

  localparam int          TMO = 4;
  localparam logic [15:0] A0  = 16'h0080;
  localparam logic [15:0] A1  = 16'h0140;
  localparam logic [15:0] IA  = 16'hFFFF;
  localparam logic [31:0] W0  = 32'hA0A0A0A0;
  localparam logic [31:0] W1  = 32'hB1B1B1B1;
  localparam logic [3:0]  K0  = 4'h3;
  localparam logic [3:0]  K1  = 4'hC;
  localparam logic [31:0] RD  = 32'h12345678;
  localparam logic [31:0] EB  = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_ren, m0_wen, m1_ren, m1_wen;
  logic [15:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wr_mask, m1_wr_mask;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_rd_valid, m0_wr_done, m1_rd_valid, m1_wr_done;
  logic        mem_ren, mem_wen;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wr_mask;
  logic [31:0] mem_rdata;
  logic        mem_rd_valid;
  logic        err;

  mem_arbiter #(.TIMEOUT_CYCLES(TMO), .ERR_DATA(EB)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_ren(m0_ren), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wr_mask(m0_wr_mask),
    .m0_rdata(m0_rdata), .m0_rd_valid(m0_rd_valid), .m0_wr_done(m0_wr_done),
    .m1_ren(m1_ren), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wr_mask(m1_wr_mask),
    .m1_rdata(m1_rdata), .m1_rd_valid(m1_rd_valid), .m1_wr_done(m1_wr_done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_mask(mem_wr_mask), .mem_rdata(mem_rdata), .mem_rd_valid(mem_rd_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] m0_rdata;
    logic        m0_rd_valid;
    logic        m0_wr_done;
    logic [31:0] m1_rdata;
    logic        m1_rd_valid;
    logic        m1_wr_done;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wr_mask;
    logic        err;
  } out_t;

  // r0/r1 = {wen, ren}; dn = {m1_wr_done, m1_rd_valid, m0_wr_done, m0_rd_valid}
  typedef struct {
    logic [1:0]  r0;
    logic [1:0]  r1;
    logic        rv;
    logic [15:0] ea;
    logic        er;
    logic        ew;
    logic [3:0]  dn;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        e;
  } vec_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];
  out_t exp_o;
  int   order[8];
  int   got_n;
  int   rv_pct;
  int   k;

  // Reference model state: owner -1 means nobody holds the memory.
  int   m_owner;
  int   m_wait;
  int   m_last;
  bit   m_err;

  bit          p_act[2];
  logic        p_ren[2];
  logic        p_wen[2];
  logic [15:0] p_addr[2];
  logic [31:0] p_wd[2];
  logic [3:0]  p_mk[2];

  function automatic out_t dut_out();
    out_t o;
    o.m0_rdata = m0_rdata;     o.m0_rd_valid = m0_rd_valid; o.m0_wr_done = m0_wr_done;
    o.m1_rdata = m1_rdata;     o.m1_rd_valid = m1_rd_valid; o.m1_wr_done = m1_wr_done;
    o.mem_ren = mem_ren;       o.mem_wen = mem_wen;         o.mem_addr = mem_addr;
    o.mem_wdata = mem_wdata;   o.mem_wr_mask = mem_wr_mask; o.err = err;
    return o;
  endfunction

  function automatic out_t idle_out(input logic e);
    out_t o = '0;
    o.mem_addr    = IA;
    o.mem_wr_mask = 4'hF;
    o.err         = e;
    return o;
  endfunction

  function automatic out_t vec_exp(input vec_t v);
    out_t o = idle_out(v.e);
    o.mem_addr = v.ea;
    o.mem_ren  = v.er;
    o.mem_wen  = v.ew;
    if (v.ea == A0) begin
      o.mem_wdata = W0; o.mem_wr_mask = K0;
    end else if (v.ea == A1) begin
      o.mem_wdata = W1; o.mem_wr_mask = K1;
    end
    {o.m1_wr_done, o.m1_rd_valid, o.m0_wr_done, o.m0_rd_valid} = v.dn;
    o.m0_rdata = v.d0;
    o.m1_rdata = v.d1;
    return o;
  endfunction

  function automatic vec_t mk(input logic [1:0] r0, input logic [1:0] r1, input logic rv,
                              input logic [15:0] ea, input logic er, input logic ew,
                              input logic [3:0] dn, input logic [31:0] d0, input logic [31:0] d1,
                              input logic e);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.rv = rv; v.ea = ea; v.er = er; v.ew = ew;
    v.dn = dn; v.d0 = d0; v.d1 = d1; v.e = e;
    return v;
  endfunction

  task automatic check_out(input string name, input out_t got, input out_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic set_ports(input logic [1:0] r0, input logic [1:0] r1);
    {m0_wen, m0_ren} = r0;
    {m1_wen, m1_ren} = r1;
  endtask

  task automatic model_reset();
    m_owner = -1; m_wait = 0; m_last = 1; m_err = 0;
  endtask

  // Rules-level model: who owns the bus, how long the read has waited, who won last.
  task automatic model_step(output out_t e);
    bit q0, q1, ren, wen;
    int x, pick;
    logic [31:0] val;
    e = idle_out(m_err);
    if (m_owner < 0) begin
      q0 = m0_ren | m0_wen;
      q1 = m1_ren | m1_wen;
      pick = -1;
      if (q0 && q1)  pick = 1 - m_last;
      else if (q0)   pick = 0;
      else if (q1)   pick = 1;
      if (pick >= 0) begin
        m_owner = pick; m_last = pick; m_wait = 0;
      end
    end else begin
      x = m_owner;
      ren = (x == 0) ? m0_ren : m1_ren;
      wen = (x == 0) ? m0_wen : m1_wen;
      e.mem_addr    = (x == 0) ? m0_addr : m1_addr;
      e.mem_wdata   = (x == 0) ? m0_wdata : m1_wdata;
      e.mem_wr_mask = (x == 0) ? m0_wr_mask : m1_wr_mask;
      m_owner = -1;
      if (wen) begin
        e.mem_wen = 1'b1;
        if (x == 0) e.m0_wr_done = 1'b1; else e.m1_wr_done = 1'b1;
      end else if (ren) begin
        e.mem_ren = 1'b1;
        val = 32'h0;
        if (mem_rd_valid) begin
          val = mem_rdata;
        end else begin
          m_wait++;
          if (m_wait == TMO) begin
            val = EB; m_err = 1; e.err = 1'b1;
          end else begin
            m_owner = x;
          end
        end
        if (m_owner < 0) begin
          if (x == 0) begin e.m0_rd_valid = 1'b1; e.m0_rdata = val; end
          else        begin e.m1_rd_valid = 1'b1; e.m1_rdata = val; end
        end
      end
    end
  endtask

  initial begin
    set_ports(2'b00, 2'b00);
    m0_addr = A0; m0_wdata = W0; m0_wr_mask = K0;
    m1_addr = A1; m1_wdata = W1; m1_wr_mask = K1;
    mem_rdata = RD; mem_rd_valid = 1'b0;

    // REQ-037 both write after reset, port 0 first
    vq.push_back(mk(2'b10, 2'b10, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b10, 2'b10, 0, A0, 0, 1, 4'b0010, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b10, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b10, 0, A1, 0, 1, 4'b1000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    // m0 read answered on the third owned cycle; response in IDLE ignored
    vq.push_back(mk(2'b01, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b01, 2'b00, 0, A0, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b01, 2'b00, 0, A0, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b01, 2'b00, 1, A0, 1, 0, 4'b0001, RD, 0, 0));
    vq.push_back(mk(2'b00, 2'b00, 1, IA, 0, 0, 4'b0000, 0, 0, 0));
    // response arriving on the timeout cycle completes normally
    vq.push_back(mk(2'b00, 2'b01, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A1, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A1, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A1, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 1, A1, 1, 0, 4'b0100, 0, RD, 0));
    vq.push_back(mk(2'b00, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    // ren+wen together is a write
    vq.push_back(mk(2'b11, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b11, 2'b00, 0, A0, 0, 1, 4'b0010, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    // m0 abandons its read, late response ignored, m1 then served
    vq.push_back(mk(2'b01, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b01, 2'b01, 0, A0, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A0, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 1, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 1, A1, 1, 0, 4'b0100, 0, RD, 0));
    vq.push_back(mk(2'b00, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    // m1 read times out on the fourth wait cycle; err sticks
    vq.push_back(mk(2'b00, 2'b01, 0, IA, 0, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A1, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A1, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A1, 1, 0, 4'b0000, 0, 0, 0));
    vq.push_back(mk(2'b00, 2'b01, 0, A1, 1, 0, 4'b0100, 0, EB, 1));
    vq.push_back(mk(2'b00, 2'b00, 0, IA, 0, 0, 4'b0000, 0, 0, 1));
    vq.push_back(mk(2'b00, 2'b00, 1, IA, 0, 0, 4'b0000, 0, 0, 1));

    // Outputs idle during reset even with requests present
    #2;
    check_out("reset_idle", dut_out(), idle_out(1'b0));
    m0_ren = 1'b1; m1_wen = 1'b1; mem_rd_valid = 1'b1;
    @(posedge clk); #1;
    check_out("reset_hold", dut_out(), idle_out(1'b0));
    @(negedge clk);
    set_ports(2'b00, 2'b00); mem_rd_valid = 1'b0; rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      set_ports(vq[i].r0, vq[i].r1);
      mem_rd_valid = vq[i].rv;
      #1;
      check_out($sformatf("vec%0d", i), dut_out(), vec_exp(vq[i]));
    end

    // Reset while m0 read is pending
    @(negedge clk);
    set_ports(2'b01, 2'b00); mem_rd_valid = 1'b0;
    #1;
    check_out("rst_pre", dut_out(), idle_out(1'b1));
    @(negedge clk); #1;
    exp_o = idle_out(1'b1);
    exp_o.mem_ren = 1'b1; exp_o.mem_addr = A0; exp_o.mem_wdata = W0; exp_o.mem_wr_mask = K0;
    check_out("rst_own", dut_out(), exp_o);
    #2 rst_n = 1'b0;
    #1;
    check_out("rst_async", dut_out(), idle_out(1'b0));
    mem_rd_valid = 1'b1;
    @(negedge clk); #1;
    check_out("rst_held", dut_out(), idle_out(1'b0));
    @(negedge clk);
    rst_n = 1'b1; set_ports(2'b00, 2'b00); mem_rd_valid = 1'b0;

    // Both ports reading continuously: grants alternate starting with port 0
    @(negedge clk);
    set_ports(2'b01, 2'b01); mem_rd_valid = 1'b1;
    got_n = 0;
    for (int c = 0; c < 40 && got_n < 8; c++) begin
      #1;
      if (m0_rd_valid && got_n < 8) begin order[got_n] = 0; got_n++; end
      if (m1_rd_valid && got_n < 8) begin order[got_n] = 1; got_n++; end
      @(negedge clk);
    end
    check_int("alt_count", got_n, 8);
    for (int i = 0; i < got_n; i++) check_int($sformatf("alt_order%0d", i), order[i], i % 2);

    // Random traffic against the model
    set_ports(2'b00, 2'b00); mem_rd_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int p = 0; p < 2; p++) p_act[p] = 0;
    rv_pct = 3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc % 150 == 0) rv_pct = $urandom_range(0, 6);
      for (int p = 0; p < 2; p++) begin
        if (p_act[p]) begin
          if ($urandom_range(0, 24) == 0) p_act[p] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          p_act[p] = 1;
          k = $urandom_range(0, 9);
          p_ren[p]  = (k < 6) || (k == 9);
          p_wen[p]  = (k >= 6);
          p_addr[p] = 16'($urandom);
          p_wd[p]   = $urandom;
          p_mk[p]   = 4'($urandom);
        end
      end
      m0_ren = p_act[0] & p_ren[0]; m0_wen = p_act[0] & p_wen[0];
      m1_ren = p_act[1] & p_ren[1]; m1_wen = p_act[1] & p_wen[1];
      m0_addr = p_addr[0]; m0_wdata = p_wd[0]; m0_wr_mask = p_mk[0];
      m1_addr = p_addr[1]; m1_wdata = p_wd[1]; m1_wr_mask = p_mk[1];
      mem_rd_valid = ($urandom_range(0, 9) < rv_pct);
      mem_rdata = $urandom;
      #1;
      model_step(exp_o);
      check_out($sformatf("rand%0d", cyc), dut_out(), exp_o);
      if (exp_o.m0_rd_valid || exp_o.m0_wr_done) p_act[0] = 0;
      if (exp_o.m1_rd_valid || exp_o.m1_wr_done) p_act[1] = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYCLES, 255: read cycles waited for mem_rd_valid before forced completion.
REQ-003 Parameter ERR_DATA, 32'hDEADBEEF: rdata returned on a timed-out read.
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 mN_ren  input  1  read request from port N (N = 0 CPU, 1 loader/debug), held until mN_rd_valid.
REQ-007 mN_wen  input  1  write request from port N, held until mN_wr_done.
REQ-008 mN_addr  input  16  byte address; mN_wdata  input  32; mN_wr_mask  input  4.
REQ-009 mN_rdata  output  32  read data; mN_rd_valid  output  1  read complete; mN_wr_done  output  1  write complete.
REQ-010 mem_ren, mem_wen  output  1; mem_addr  output  16; mem_wdata  output  32; mem_wr_mask  output  4.
REQ-011 mem_rdata  input  32; mem_rd_valid  input  1  memory read response.
REQ-012 err  output  1  sticky read-timeout flag.

Function
REQ-013 States SHALL be IDLE, OWN0, OWN1.
REQ-014 IDLE: request from one port only -> OWNx of that port next cycle; no request -> stay IDLE.
REQ-015 IDLE, both ports requesting: grant the port not in last_grant; last_grant updates on every grant.
REQ-016 In OWNx, mem_* strobes, address, data and mask SHALL be driven combinationally from port x; the other port sees no strobes.
REQ-017 In IDLE: mem_ren=0, mem_wen=0, mem_addr=16'hFFFF, mem_wdata=0, mem_wr_mask=4'b1111.
REQ-018 Both mx_ren and mx_wen high: treat as write; mem_ren SHALL stay low.
REQ-019 Write in OWNx: mem_wen asserted exactly one cycle, mx_wr_done pulses that same cycle, next state IDLE.
REQ-020 Read in OWNx: mem_ren held until mem_rd_valid; mx_rdata=mem_rdata and mx_rd_valid=1 in that same cycle; next state IDLE.
REQ-021 mx_rdata SHALL read 0 whenever mx_rd_valid is low; non-owner outputs SHALL stay 0.
REQ-022 Latency: request seen in IDLE at cycle N -> mem strobe at N+1 -> earliest completion N+1.
REQ-023 Owner drops both requests before completion: return to IDLE next cycle, no completion pulse, late mem_rd_valid ignored.
REQ-024 A 16-bit wait counter SHALL clear on grant and increment each OWN read cycle without mem_rd_valid.
REQ-025 Counter reaching TIMEOUT_CYCLES: mx_rd_valid=1, mx_rdata=ERR_DATA, err set, next state IDLE.
REQ-026 mem_rd_valid in the same cycle the timeout is reached: normal completion, err unchanged.
REQ-027 mem_rd_valid in IDLE SHALL be ignored.
REQ-028 Fairness: a continuously requesting port SHALL be granted within one other transaction plus one IDLE cycle.
REQ-029 err SHALL clear only on reset.

Reset
REQ-030 On rst_n low, immediately: state IDLE, last_grant=1 (port 0 wins first tie), counter 0, err 0.
REQ-031 During reset, all outputs SHALL take their REQ-017 / REQ-021 idle values.
REQ-032 Reset asserted mid-transaction SHALL drop mem strobes asynchronously; no completion pulse SHALL be issued.

Structure
REQ-033 The shared package SHALL hold the state encoding, port indices, idle address 16'hFFFF, default TIMEOUT_CYCLES and ERR_DATA.
REQ-034 One sub-module SHALL be used: rr_arb2, a two-way round-robin picker (req[1:0], last_grant -> grant index, valid).
REQ-035 The sequencer, wait counter and muxing SHALL remain in mem_arbiter.

Verification
REQ-036 m0 read addr 0x0080, memory returns 0x12345678 after 3 cycles -> m0_rd_valid one cycle with that data, m1 outputs 0.
REQ-037 m0 and m1 both write in the same cycle after reset -> m0 granted first, m1 next; mem_wen pulses one cycle each; order 0,1.
REQ-038 Both ports continuously reading -> grants alternate 0,1,0,1 over 8 transactions.
REQ-039 m1 read with no memory response, TIMEOUT_CYCLES=4 -> m1_rd_valid with 0xDEADBEEF on 4th wait cycle; err=1 and stays 1.
REQ-040 rst_n pulled low while OWN0 read pending -> mem_ren low in the same cycle, state IDLE, no m0_rd_valid pulse.
REQ-041 m0 drops ren before response, memory responds next cycle -> no m0_rd_valid; a pending m1 request is granted.
